// File: rtl/a2d_spi_resp.sv
`timescale 1ns/1ps
// SPI responder for the 16-bit A2D protocol: decodes the channel from each command
// frame and returns that channel's 12-bit sample in the following frame.
module a2d_spi_resp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] smpl,
    output logic        cmd_vld,
    output logic [2:0]  cmd_chnnl,
    output logic        frame_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [2:0]  r_ssSync;
    logic [2:0]  r_sclkSync;
    logic [1:0]  r_mosiSync;
    logic [15:0] r_txShft;
    logic [15:0] r_rxShft;
    logic [4:0]  r_bitCnt;
    logic [2:0]  r_cmdChnnl;
    logic        r_cmdVld;
    logic        r_frameErr;

    logic        w_ssFall;
    logic        w_ssRise;
    logic        w_sclkRise;
    logic        w_sclkFall;
    logic        w_load;
    logic        w_sample;
    logic        w_shiftOut;
    logic        w_endOk;
    logic        w_endErr;
    logic [6:0]  w_selBase;
    logic [11:0] w_selSmpl;

    // Third stage of each synchronizer holds the previous value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ssSync   <= 3'b111;
            r_sclkSync <= 3'b111;
            r_mosiSync <= 2'b11;
        end else begin
            r_ssSync   <= {r_ssSync[1:0], SS_n};
            r_sclkSync <= {r_sclkSync[1:0], SCLK};
            r_mosiSync <= {r_mosiSync[0], MOSI};
        end
    end

    assign w_ssFall   =  r_ssSync[2]   & ~r_ssSync[1];
    assign w_ssRise   = ~r_ssSync[2]   &  r_ssSync[1];
    assign w_sclkRise = ~r_sclkSync[2] &  r_sclkSync[1];
    assign w_sclkFall =  r_sclkSync[2] & ~r_sclkSync[1];

    assign w_selBase  = {4'h0, r_cmdChnnl} * 7'd12;
    assign w_selSmpl  = smpl[w_selBase +: 12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Frame termination takes priority over any SCLK edge in the same cycle
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        w_shiftOut  = 1'b0;
        w_endOk     = 1'b0;
        w_endErr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ssFall) begin
                    w_nextState = SHIFT;
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                if (w_ssRise) begin
                    w_nextState = IDLE;
                    if (r_bitCnt == 5'd16) begin
                        w_endOk = 1'b1;
                    end else begin
                        w_endErr = 1'b1;
                    end
                end else if (w_sclkRise) begin
                    w_sample = 1'b1;
                end else if (w_sclkFall && (r_bitCnt != 5'd0)) begin
                    w_shiftOut = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Leading SCLK fall of a frame does not shift, so bit 15 meets the first rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txShft   <= 16'h0000;
            r_rxShft   <= 16'h0000;
            r_bitCnt   <= 5'd0;
            r_cmdChnnl <= 3'd0;
            r_cmdVld   <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_cmdVld   <= w_endOk;
            r_frameErr <= w_endErr;
            if (w_load) begin
                r_txShft <= {4'h0, w_selSmpl};
                r_bitCnt <= 5'd0;
            end
            if (w_sample) begin
                r_rxShft <= {r_rxShft[14:0], r_mosiSync[1]};
                if (r_bitCnt != 5'd31) begin
                    r_bitCnt <= r_bitCnt + 5'd1;
                end
            end
            if (w_shiftOut) begin
                r_txShft <= {r_txShft[14:0], 1'b0};
            end
            if (w_endOk) begin
                r_cmdChnnl <= r_rxShft[13:11];
            end
        end
    end

    assign MISO      = (r_state == SHIFT) & r_txShft[15];
    assign cmd_vld   = r_cmdVld;
    assign frame_err = r_frameErr;
    assign cmd_chnnl = r_cmdChnnl;

endmodule

// File: tb/tb_a2d_spi_resp.sv
`timescale 1ns/1ps
// Bench for a2d_spi_resp: a bus-functional SPI master drives frames while two
// monitors check MISO words and end-of-frame pulses against a queued channel model.
module tb_a2d_spi_resp;

    typedef struct {
        logic [15:0] word;
        int          n;
    } misoExp_t;

    typedef struct {
        logic       isErr;
        logic [2:0] ch;
    } evtExp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [95:0] smpl;
    logic        cmd_vld;
    logic [2:0]  cmd_chnnl;
    logic        frame_err;

    logic [11:0] chanVal [8];
    logic [2:0]  modelCh = 3'd0;
    misoExp_t    misoQ[$];
    evtExp_t     evtQ[$];
    int          compared = 0;
    int          mismatched = 0;

    a2d_spi_resp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .smpl      (smpl),
        .cmd_vld   (cmd_vld),
        .cmd_chnnl (cmd_chnnl),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) smpl[12*i +: 12] = chanVal[i];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One master frame; resetAt > 0 pulses rst_n after that many rises instead of ending normally
    task automatic applyStimulus(input logic [15:0] mosi, input int nRises, input int changeAt,
                                 input int changeCh, input logic [11:0] changeVal, input int resetAt);
        misoExp_t me;
        evtExp_t  ee;
        logic [15:0] respWord;
        int ph;
        respWord = {4'h0, chanVal[modelCh]};
        if (resetAt == 0) begin
            me.word = respWord;
            me.n    = nRises;
            misoQ.push_back(me);
            ee.isErr = (nRises != 16);
            if (nRises == 16) modelCh = mosi[13:11];
            ee.ch = modelCh;
            evtQ.push_back(ee);
        end
        @(negedge clk) SS_n = 1'b0;
        repeat ($urandom_range(4, 7)) @(negedge clk);
        for (int i = 0; i < nRises; i++) begin
            ph = $urandom_range(4, 7);
            SCLK = 1'b0;
            MOSI = (i < 16) ? mosi[15-i] : 1'($urandom);
            repeat (ph) @(negedge clk);
            SCLK = 1'b1;
            repeat (ph) @(negedge clk);
            if (i + 1 == changeAt) chanVal[changeCh] = changeVal;
            if (i + 1 == resetAt) begin
                checkOutput("pre_rst_miso", 32'(MISO), 32'(respWord[15-i]));
                rst_n = 1'b0;
                #1;
                checkOutput("rst_miso", 32'(MISO), 32'd0);
                checkOutput("rst_cmd_vld", 32'(cmd_vld), 32'd0);
                checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
                checkOutput("rst_cmd_chnnl", 32'(cmd_chnnl), 32'd0);
                SS_n = 1'b1;
                MOSI = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                modelCh = 3'd0;
                repeat (6) @(negedge clk);
                return;
            end
        end
        repeat ($urandom_range(4, 6)) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat ($urandom_range(6, 9)) @(negedge clk);
    endtask

    // End-of-frame pulse monitor
    initial begin
        evtExp_t ee;
        forever begin
            @(negedge clk);
            if (rst_n && (cmd_vld || frame_err)) begin
                if (evtQ.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'd0, cmd_vld, frame_err}, 32'd0);
                end else begin
                    ee = evtQ.pop_front();
                    checkOutput("evt_cmd_vld", 32'(cmd_vld), 32'(!ee.isErr));
                    checkOutput("evt_frame_err", 32'(frame_err), 32'(ee.isErr));
                    checkOutput("evt_cmd_chnnl", 32'(cmd_chnnl), 32'(ee.ch));
                end
            end
        end
    end

    // MISO monitor: captures MISO at every SCLK rise inside a frame
    initial begin
        misoExp_t    me;
        logic [31:0] cap;
        logic [31:0] expVec;
        int          nbits;
        bit          aborted;
        forever begin
            @(negedge SS_n);
            cap = 32'd0;
            nbits = 0;
            aborted = 1'b0;
            forever begin
                @(posedge SCLK or posedge SS_n or negedge rst_n);
                if (SS_n) break;
                else if (!rst_n) aborted = 1'b1;
                else begin
                    cap = {cap[30:0], MISO};
                    nbits++;
                end
            end
            if (!aborted) begin
                if (misoQ.size() == 0) begin
                    checkOutput("unexpected_frame", 32'(nbits), 32'hFFFF_FFFF);
                end else begin
                    me = misoQ.pop_front();
                    expVec = 32'd0;
                    for (int i = 0; i < me.n; i++)
                        expVec = {expVec[30:0], (i < 16) ? me.word[15-i] : 1'b0};
                    checkOutput("miso_nbits", 32'(nbits), 32'(me.n));
                    checkOutput("miso_data", cap, expVec);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] cmdWord;
        int nr;
        for (int i = 0; i < 8; i++) chanVal[i] = 12'h000;
        repeat (4) @(negedge clk);
        checkOutput("reset_miso", 32'(MISO), 32'd0);
        checkOutput("reset_cmd_vld", 32'(cmd_vld), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_cmd_chnnl", 32'(cmd_chnnl), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chanVal[0] = 12'hABC;
        applyStimulus(16'h1800, 16, 0, 0, 12'h000, 0);
        chanVal[3] = 12'h5A5;
        applyStimulus(16'h3800, 16, 0, 0, 12'h000, 0);
        chanVal[7] = 12'h111;
        applyStimulus(16'h3800, 16, 5, 7, 12'h222, 0);
        applyStimulus(16'h3800, 16, 0, 0, 12'h000, 0);
        applyStimulus(16'h1000, 9, 0, 0, 12'h000, 0);

        for (int n = 0; n < 8; n++) chanVal[n] = 12'(12'h100 * n + n);
        for (int n = 0; n < 8; n++) begin
            cmdWord = {2'b00, 3'(n), 11'h000};
            applyStimulus(cmdWord, 16, 0, 0, 12'h000, 0);
            applyStimulus(cmdWord, 16, 0, 0, 12'h000, 0);
        end

        applyStimulus(16'h2800, 16, 0, 0, 12'h000, 0);
        chanVal[5] = 12'hFFF;
        applyStimulus(16'h1000, 16, 0, 0, 12'h000, 8);
        checkOutput("post_rst_cmd_chnnl", 32'(cmd_chnnl), 32'd0);
        applyStimulus(16'h0800, 16, 0, 0, 12'h000, 0);

        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 8; i++) chanVal[i] = 12'($urandom);
            nr = ($urandom_range(0, 9) < 7) ? 16 : $urandom_range(0, 20);
            applyStimulus(16'($urandom), nr, $urandom_range(1, 16), $urandom_range(0, 7), 12'($urandom), 0);
        end

        repeat (20) @(negedge clk);
        checkOutput("evt_queue_drained", 32'(evtQ.size()), 32'd0);
        checkOutput("miso_queue_drained", 32'(misoQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

SPI responder (slave) for the 16-bit A2D conversion protocol: the ADC-side counterpart of the A2D SPI master interface. It decodes the 3-bit channel from each command frame and returns that channel's 12-bit sample in the following frame, the ADC's one-frame pipelined response. It serves as the synthesizable ADC stand-in for FPGA bring-up and as the bus-functional responder in A2D interface benches.

## Interface
- No parameters; frame length fixed at 16 bits, 8 channels × 12 bits.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- SS_n  in  1  slave select from master, active-low, asynchronous to clk
- SCLK  in  1  serial clock from master, idles high, asynchronous to clk
- MOSI  in  1  command data from master, MSB first
- MISO  out  1  response data to master, MSB first
- smpl  in  96  channel samples; channel n = smpl[12n+11:12n]
- cmd_vld  out  1  one-clk pulse: valid 16-bit command frame received
- cmd_chnnl  out  3  channel of last valid command
- frame_err  out  1  one-clk pulse: frame ended with bit count ≠ 16

## Operation
- SS_n, SCLK and MOSI each pass through a 2-flop synchronizer (reset value 1); edges are detected on a third flop stage. SCLK rise = sample point, SCLK fall = shift point.
- States:
  - IDLE: SS_n high.
  - SHIFT: frame active.
  - Transitions: IDLE→SHIFT on synced SS_n fall; SHIFT→IDLE on synced SS_n rise.
- On entry to SHIFT:
  - tx_shft[15:0] ← {4'h0, smpl[12·cmd_chnnl +: 12]} (snapshot of smpl at that clk).
  - bit_cnt ← 0.
- In SHIFT, on each SCLK rise:
  - rx_shft ← {rx_shft[14:0], MOSI_sync}.
  - bit_cnt increments, saturating at 31.
- In SHIFT, on each SCLK fall with bit_cnt ≠ 0: tx_shft ← {tx_shft[14:0], 1'b0}.
  - The leading fall of the frame (bit_cnt = 0) does not shift, so bit 15 is on MISO for the first rise.
- MISO = tx_shft[15] while in SHIFT, else 0.
- On SHIFT→IDLE:
  - If bit_cnt = 16: cmd_chnnl ← rx_shft[13:11] and cmd_vld pulses. rx_shft[15:14] and rx_shft[10:0] are ignored.
  - Otherwise: frame_err pulses and cmd_chnnl is unchanged.
- Response pipelining: frame k returns the sample for the channel commanded in frame k−1. The first frame after reset returns channel 0.
- Reset values: MISO 0, cmd_vld 0, frame_err 0, cmd_chnnl 0, state IDLE, bit_cnt 0, tx_shft 0, rx_shft 0.

## Timing
- Input-to-action latency is 3 clk (sync + edge detect).
- Required master timing:
  - SCLK high and low phases each ≥ 4 clk.
  - SS_n fall to first SCLK fall ≥ 4 clk.
  - Last SCLK rise to SS_n rise ≥ 4 clk.
- MISO updates 3 clk after each real SCLK fall. It is stable for ≥ 1 clk before the next real rise.
- cmd_vld / frame_err assert 3 clk after the real SS_n rise, for exactly 1 clk. cmd_chnnl updates in that same cycle.
- SS_n fall and rise on the same synced edge cannot occur; SS_n pulses shorter than 3 clk may be missed.
- SS_n rising mid-frame: the frame aborts with frame_err. The next SS_n fall reloads tx_shft; there is no carry-over.
- An SCLK edge coincident with the SS_n rise (same synced cycle) is ignored; the termination is evaluated first.
- More than 16 SCLK rises: rx keeps the last 16 bits, bit_cnt ≠ 16 → frame_err.
- rst_n asserted mid-frame: all state returns to reset values immediately, and MISO drops to 0.

## Test plan
- Reset, then one frame with MOSI = 16'h1800 (channel 3) and smpl ch0 = 12'hABC → MISO shifts 16'h0ABC, cmd_vld pulses, cmd_chnnl = 3.
- Next frame with ch3 = 12'h5A5 and MOSI = 16'h3800 (channel 7) → MISO returns 16'h05A5 and cmd_chnnl = 7.
- smpl ch7 changed 12'h111→12'h222 mid-frame (after SS_n fall) → that frame returns 16'h0111; the next frame for ch7 returns 16'h0222.
- SS_n released after 9 SCLK rises → frame_err pulses once, cmd_vld stays 0, and cmd_chnnl keeps its prior value.
- Back-to-back with the master's garbage-then-read sequence, channels 0..7, smpl ch n = 12'h100·n+n → each second frame's rd_data[11:0] = the expected value.
- rst_n pulsed after 8 bits of a frame → outputs return to 0; the following full frame returns channel 0 data.
